whack_round_ctrl: RTL

- Game-round controller for the whack-a-mole datapath.
- Sequences the mole position generator: requests new positions, latches the returned position, and times each mole.
- Judges debounced button presses against the latched mole; keeps score and lives.
- Sits between the button debouncers, the mole position generator and the display/score logic.

---
 rtl/whack_round_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/whack_round_ctrl.sv
// Round controller for the whack-a-mole datapath: requests mole positions,
// times each mole, judges button presses and keeps score and lives.
module whack_round_ctrl #(
  parameter int MOLE_TIMEOUT = 20000,
  parameter int HIT_HOLD     = 5000,
  parameter int START_LIVES  = 3,
  parameter int SCORE_MAX    = 99
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [4:0] i_btn,
  input  logic [2:0] i_mole_position,
  input  logic       i_position_changed,
  output logic       o_change_position,
  output logic [2:0] o_mole_pos,
  output logic       o_mole_valid,
  output logic [7:0] o_score,
  output logic [1:0] o_lives,
  output logic       o_hit,
  output logic       o_miss,
  output logic       o_game_over,
  output logic [2:0] o_state
);

  // Generator handshake: o_change_position is a one-cycle request issued
  // while in REQ; the generator answers later with a one-cycle
  // i_position_changed, which is only accepted in WAIT_POS.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT_POS = 3'd2,
    S_ACTIVE   = 3'd3,
    S_HOLD     = 3'd4,
    S_OVER     = 3'd5
  } state_t;

  localparam logic [23:0] MOLE_LOAD = 24'(MOLE_TIMEOUT - 1);
  localparam logic [23:0] HOLD_LOAD = 24'(HIT_HOLD - 1);
  localparam logic [1:0]  LIVES_V   = 2'(START_LIVES);
  localparam logic [7:0]  SCORE_V   = 8'(SCORE_MAX);

  state_t      state;
  logic [23:0] timer;
  logic        correct_hit;
  logic        any_btn;
  logic [1:0]  lives_dec;
  logic [7:0]  score_inc;

  // Anti-mash: a hit needs exactly the mole's bit and nothing else.
  assign correct_hit = (i_btn == (5'b00001 << o_mole_pos));
  assign any_btn     = |i_btn;
  assign lives_dec   = (o_lives != 2'd0) ? (o_lives - 2'd1) : 2'd0;
  assign score_inc   = (o_score < SCORE_V) ? (o_score + 8'd1) : SCORE_V;
  assign o_state     = 3'(state);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state             <= S_IDLE;
      timer             <= 24'd0;
      o_score           <= 8'd0;
      o_lives           <= LIVES_V;
      o_mole_pos        <= 3'd0;
      o_change_position <= 1'b0;
      o_mole_valid      <= 1'b0;
      o_hit             <= 1'b0;
      o_miss            <= 1'b0;
      o_game_over       <= 1'b0;
    end else begin
      o_change_position <= 1'b0;
      o_hit             <= 1'b0;
      o_miss            <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state             <= S_REQ;
            o_change_position <= 1'b1;
            o_score           <= 8'd0;
            o_lives           <= LIVES_V;
          end
        end
        S_REQ: begin
          state <= S_WAIT_POS;
        end
        S_WAIT_POS: begin
          if (i_position_changed) begin
            if (i_mole_position < 3'd5) begin
              o_mole_pos   <= i_mole_position;
              timer        <= MOLE_LOAD;
              o_mole_valid <= 1'b1;
              state        <= S_ACTIVE;
            end else begin
              state             <= S_REQ;
              o_change_position <= 1'b1;
            end
          end
        end
        S_ACTIVE: begin
          // A correct press on the timeout cycle still counts as a hit.
          if (correct_hit) begin
            o_hit        <= 1'b1;
            o_score      <= score_inc;
            timer        <= HOLD_LOAD;
            o_mole_valid <= 1'b0;
            state        <= S_HOLD;
          end else if (any_btn || (timer == 24'd0)) begin
            o_miss       <= 1'b1;
            o_lives      <= lives_dec;
            o_mole_valid <= 1'b0;
            if (lives_dec == 2'd0) begin
              o_game_over <= 1'b1;
              state       <= S_OVER;
            end else begin
              o_change_position <= 1'b1;
              state             <= S_REQ;
            end
          end else begin
            timer <= timer - 24'd1;
          end
        end
        S_HOLD: begin
          if (timer == 24'd0) begin
            o_change_position <= 1'b1;
            state             <= S_REQ;
          end else begin
            timer <= timer - 24'd1;
          end
        end
        S_OVER: begin
          if (i_start) begin
            o_game_over       <= 1'b0;
            o_score           <= 8'd0;
            o_lives           <= LIVES_V;
            o_change_position <= 1'b1;
            state             <= S_REQ;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
